// File: rtl/lc3b_exec_arith.sv
// Execute-stage arithmetic for the LC-3b pipeline: ALU, PC-relative offset
// adjust/add, and the EX/MEM result registers.
module lc3b_exec_arith (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [2:0]  aluop,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  offset_sel,
  input  logic [10:0] offset_field,
  input  logic [15:0] pc,
  output logic [15:0] alu_out,
  output logic [15:0] target,
  output logic [15:0] alu_reg_out,
  output logic [15:0] target_reg_out
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;

  localparam logic [1:0] OFS_ADJ6  = 2'b00;
  localparam logic [1:0] OFS_ADJ9  = 2'b01;
  localparam logic [1:0] OFS_ADJ11 = 2'b10;

  logic [3:0]  shamt;
  logic [15:0] adj_ofs;
  logic [15:0] alu_q, alu_d;
  logic [15:0] target_q, target_d;

  assign shamt = b[3:0];

  always_comb begin
    alu_out = 16'h0000;
    case (aluop)
      OP_ADD:  alu_out = a + b;
      OP_AND:  alu_out = a & b;
      OP_NOT:  alu_out = ~a;
      OP_PASS: alu_out = b;
      OP_SLL:  alu_out = a << shamt;
      OP_SRL:  alu_out = a >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(a) >>> shamt);
      default: alu_out = 16'h0000;
    endcase
  end

  // Sign-extend and shift left by one in a single concatenation.
  always_comb begin
    adj_ofs = 16'h0000;
    case (offset_sel)
      OFS_ADJ6:  adj_ofs = {{9{offset_field[5]}},  offset_field[5:0],  1'b0};
      OFS_ADJ9:  adj_ofs = {{6{offset_field[8]}},  offset_field[8:0],  1'b0};
      OFS_ADJ11: adj_ofs = {{4{offset_field[10]}}, offset_field[10:0], 1'b0};
      default:   adj_ofs = 16'h0000;
    endcase
  end

  assign target = pc + adj_ofs;

  always_comb begin
    alu_d    = alu_q;
    target_d = target_q;
    if (load) begin
      alu_d    = alu_out;
      target_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q    <= 16'h0000;
      target_q <= 16'h0000;
    end else begin
      alu_q    <= alu_d;
      target_q <= target_d;
    end
  end

  assign alu_reg_out    = alu_q;
  assign target_reg_out = target_q;

endmodule

// File: tb/tb_lc3b_exec_arith.sv
// Self-checking bench for lc3b_exec_arith: direct checks on the combinational
// outputs, queue-based scoreboard for the registered outputs.
module tb_lc3b_exec_arith;

  logic        clk = 1'b0;
  logic        reset, load;
  logic [2:0]  aluop;
  logic [15:0] a, b, pc;
  logic [1:0]  offset_sel;
  logic [10:0] offset_field;
  logic [15:0] alu_out, target, alu_reg_out, target_reg_out;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] tgt;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mdl_reg;
  int          n_chk = 0;
  int          n_fail = 0;

  lc3b_exec_arith dut (
    .clk(clk), .reset(reset), .load(load), .aluop(aluop), .a(a), .b(b),
    .offset_sel(offset_sel), .offset_field(offset_field), .pc(pc),
    .alu_out(alu_out), .target(target),
    .alu_reg_out(alu_reg_out), .target_reg_out(target_reg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  // Reference ALU: shifts built bit by bit rather than with shift operators.
  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    int sh;
    sh = int'(y[3:0]);
    r  = 16'h0000;
    case (op)
      3'd0: r = 16'((32'(x) + 32'(y)) % 32'h10000);
      3'd1: for (int i = 0; i < 16; i++) r[i] = x[i] & y[i];
      3'd2: for (int i = 0; i < 16; i++) r[i] = !x[i];
      3'd3: r = y;
      3'd4: for (int i = 0; i < 16; i++) r[i] = (i >= sh) ? x[i-sh] : 1'b0;
      3'd5: for (int i = 0; i < 16; i++) r[i] = (i + sh <= 15) ? x[i+sh] : 1'b0;
      3'd6: for (int i = 0; i < 16; i++) r[i] = (i + sh <= 15) ? x[i+sh] : x[15];
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] tgt_model(input logic [1:0] sel, input logic [10:0] f, input logic [15:0] p);
    logic [15:0] ext;
    int w;
    w = (sel == 2'b00) ? 6 : (sel == 2'b01) ? 9 : 11;
    ext = 16'h0000;
    if (sel != 2'b11)
      for (int i = 0; i < 16; i++) ext[i] = (i < w) ? f[i] : f[w-1];
    return p + {ext[14:0], 1'b0};
  endfunction

  // Drive one cycle: check combinational outputs, push expected register
  // contents, take the edge, then pop and compare registered outputs.
  task automatic step(input string tag, input logic rst, input logic ld, input logic [2:0] op,
                      input logic [15:0] xa, input logic [15:0] xb, input logic [1:0] sel,
                      input logic [10:0] fld, input logic [15:0] p);
    exp_t e, got;
    reset = rst; load = ld; aluop = op; a = xa; b = xb;
    offset_sel = sel; offset_field = fld; pc = p;
    #1;
    chk({tag, ".alu"}, alu_out, alu_model(op, xa, xb));
    chk({tag, ".tgt"}, target, tgt_model(sel, fld, p));
    if (rst)     mdl_reg = '0;
    else if (ld) mdl_reg = '{alu: alu_model(op, xa, xb), tgt: tgt_model(sel, fld, p)};
    sb_q.push_back(mdl_reg);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s.sb: scoreboard empty, got %04h expected entry", tag, alu_reg_out);
    end else begin
      e = sb_q.pop_front();
      got = '{alu: alu_reg_out, tgt: target_reg_out};
      chk({tag, ".alu_reg"}, got.alu, e.alu);
      chk({tag, ".tgt_reg"}, got.tgt, e.tgt);
    end
  endtask

  initial begin
    mdl_reg = '0;
    reset = 1'b1; load = 1'b0; aluop = 3'd0; a = '0; b = '0;
    offset_sel = 2'b11; offset_field = '0; pc = '0;
    @(posedge clk); #1;
    chk("rst.alu_reg", alu_reg_out, 16'h0000);
    chk("rst.tgt_reg", target_reg_out, 16'h0000);

    step("add_ovf",  0, 1, 3'd0, 16'h7FFF, 16'h0001, 2'b11, 11'h000, 16'h3000);
    chk("add_ovf.c", alu_reg_out, 16'h8000);
    step("add_wrap", 0, 1, 3'd0, 16'hFFFF, 16'h0001, 2'b01, 11'h1FF, 16'h3000);
    chk("add_wrap.c", alu_reg_out, 16'h0000);
    chk("adj9.c", target_reg_out, 16'h2FFE);
    step("and",      0, 1, 3'd1, 16'hF0F0, 16'h0FF0, 2'b10, 11'h3FF, 16'h3000);
    chk("and.c", alu_reg_out, 16'h00F0);
    chk("adj11.c", target_reg_out, 16'h37FE);
    step("not",      0, 1, 3'd2, 16'h1234, 16'h0000, 2'b00, 11'h020, 16'h3000);
    chk("not.c", alu_reg_out, 16'hEDCB);
    chk("adj6.c", target_reg_out, 16'h2FC0);
    step("pass",     0, 1, 3'd3, 16'h0000, 16'hABCD, 2'b11, 11'h7FF, 16'h3000);
    chk("pass.c", alu_reg_out, 16'hABCD);
    chk("sel11.c", target_reg_out, 16'h3000);
    step("op7",      0, 1, 3'd7, 16'h1234, 16'h5678, 2'b01, 11'h001, 16'hFFFE);
    chk("op7.c", alu_reg_out, 16'h0000);
    chk("pcwrap.c", target_reg_out, 16'h0000);
    step("sll15",    0, 1, 3'd4, 16'h0001, 16'h000F, 2'b11, 11'h000, 16'h0000);
    chk("sll15.c", alu_reg_out, 16'h8000);
    step("srl4",     0, 1, 3'd5, 16'h8000, 16'h0004, 2'b11, 11'h000, 16'h0000);
    chk("srl4.c", alu_reg_out, 16'h0800);
    step("sra4n",    0, 1, 3'd6, 16'h8000, 16'h0004, 2'b11, 11'h000, 16'h0000);
    chk("sra4n.c", alu_reg_out, 16'hF800);
    step("sra4p",    0, 1, 3'd6, 16'h4000, 16'h0004, 2'b11, 11'h000, 16'h0000);
    chk("sra4p.c", alu_reg_out, 16'h0400);
    step("sll_hi",   0, 1, 3'd4, 16'h0001, 16'h0013, 2'b11, 11'h000, 16'h0000);
    chk("sll_hi.c", alu_reg_out, 16'h0008);
    step("sra0",     0, 1, 3'd6, 16'h8421, 16'hFFF0, 2'b00, 11'h7C0, 16'h1000);
    chk("sra0.c", alu_reg_out, 16'h8421);
    chk("adj6_hi.c", target_reg_out, 16'h1000);

    step("ld5",      0, 1, 3'd0, 16'h0002, 16'h0003, 2'b01, 11'h010, 16'h4000);
    chk("ld5.c", alu_reg_out, 16'h0005);
    step("hold1",    0, 0, 3'd1, 16'hFFFF, 16'h00FF, 2'b10, 11'h400, 16'h2000);
    chk("hold1.c", alu_reg_out, 16'h0005);
    chk("hold1.comb", alu_out, 16'h00FF);
    step("hold2",    0, 0, 3'd2, 16'h0F0F, 16'h0000, 2'b00, 11'h001, 16'h0000);
    chk("hold2.c", alu_reg_out, 16'h0005);

    step("rst_ld",   1, 1, 3'd3, 16'h0000, 16'h1111, 2'b11, 11'h000, 16'h5555);
    chk("rst_ld.a", alu_reg_out, 16'h0000);
    chk("rst_ld.t", target_reg_out, 16'h0000);
    step("post_rst", 0, 1, 3'd3, 16'h0000, 16'h2222, 2'b11, 11'h000, 16'h6666);
    chk("post_rst.a", alu_reg_out, 16'h2222);
    chk("post_rst.t", target_reg_out, 16'h6666);

    for (int i = 0; i < 60; i++)
      step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
           2'($urandom_range(0, 3)), 11'($urandom), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
